multi_cycle_control: RTL

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-subset control unit: a 5-state FSM whose only storage is the
// state register; all datapath controls decode combinationally from state and IR.
module multi_cycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       ExtOp,
    output logic       LuOp,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [3:0] ALUOp
);
    typedef enum logic [2:0] {
        sIF  = 3'd0,
        sID  = 3'd1,
        sEX  = 3'd2,
        sMEM = 3'd3,
        sWB  = 3'd4
    } state_t;

    state_t cur, nxt;

    logic isR, isJ, isJal, isBeq, isLw, isSw, isLui, isAndi, isJr, isJalr;
    logic isIAlu, toEx;
    logic [2:0] aluLo;

    assign isR    = (OpCode == 6'h00);
    assign isJ    = (OpCode == 6'h02);
    assign isJal  = (OpCode == 6'h03);
    assign isBeq  = (OpCode == 6'h04);
    assign isLw   = (OpCode == 6'h23);
    assign isSw   = (OpCode == 6'h2b);
    assign isLui  = (OpCode == 6'h0f);
    assign isAndi = (OpCode == 6'h0c);
    assign isJr   = isR && (Funct == 6'h08);
    assign isJalr = isR && (Funct == 6'h09);
    assign isIAlu = (OpCode == 6'h08) || (OpCode == 6'h09) || isAndi ||
                    (OpCode == 6'h0a) || (OpCode == 6'h0b);
    assign toEx   = (isR && !isJr && !isJalr) || isLw || isSw || isBeq || isLui || isIAlu;

    always_comb begin
        case (OpCode)
            6'h00:       aluLo = 3'b010;
            6'h04:       aluLo = 3'b001;
            6'h0c:       aluLo = 3'b100;
            6'h0a, 6'h0b: aluLo = 3'b101;
            default:     aluLo = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= sIF;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt         = sIF;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        ExtOp       = !isAndi;
        LuOp        = isLui;
        PCSource    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUOp       = 4'b0000;
        case (cur)
            sIF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = sID;
                end else begin
                    nxt = sIF;
                end
            end
            sID: begin
                // Branch target is precomputed here so beq can resolve in EX.
                ALUSrcB = 2'b11;
                if (isJ || isJal) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    if (isJal) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end else if (isJr || isJalr) begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b11;
                    if (isJalr) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b01;
                        MemtoReg = 2'b10;
                    end
                end else if (toEx) begin
                    nxt = sEX;
                end
            end
            sEX: begin
                ALUOp = {OpCode[0], aluLo};
                if (isBeq) begin
                    ALUSrcA     = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    nxt         = sIF;
                end else if (isR) begin
                    ALUSrcA = (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03) ? 2'b10 : 2'b01;
                    nxt     = sWB;
                end else begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    nxt     = (isLw || isSw) ? sMEM : sWB;
                end
            end
            sMEM: begin
                IorD     = 1'b1;
                MemRead  = isLw;
                MemWrite = isSw;
                if (mem_ready) nxt = isLw ? sWB : sIF;
                else           nxt = sMEM;
            end
            sWB: begin
                RegWrite = 1'b1;
                RegDst   = isR ? 2'b01 : 2'b00;
                MemtoReg = isLw ? 2'b01 : 2'b00;
            end
            default: nxt = sIF;
        endcase
        // State is forced to IF asynchronously; IF's fetch strobe must not leak out.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
        end
    end
endmodule
